// File: rtl/sig_meas_pkg.sv
// Shared types and helpers for the signal frequency meter.
package sig_meas_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas,
    StDone
  } meas_state_e;

  localparam int unsigned CNT_W = 32;

  // Edge counter must be able to hold N_PER itself, not just N_PER-1.
  function automatic int unsigned edge_cnt_width(input int unsigned n_per);
    return (n_per < 1) ? 1 : $clog2(n_per + 1);
  endfunction

endpackage

// File: rtl/xing_detect.sv
// Rising mid-level crossing detector with hysteresis; rise pulses one clock after the sample.
module xing_detect #(
  parameter int unsigned DW   = 12,
  parameter int unsigned MID  = 2048,
  parameter int unsigned HYST = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic          rise
);

  if (((MID + HYST) > ((32'd1 << DW) - 32'd1)) || (MID < HYST)) begin : g_bad_thresholds
    $error("xing_detect: thresholds MID+/-HYST fall outside the sample range");
  end

  localparam logic [DW:0] THR_HI = (DW + 1)'(MID + HYST);
  localparam logic [DW:0] THR_LO = (DW + 1)'(MID - HYST);

  logic          level_hi_q, level_hi_d;
  logic          rise_q, rise_d;
  logic [DW:0]   sample_ext;

  assign sample_ext = {1'b0, adc_data};

  always_comb begin
    level_hi_d = level_hi_q;
    rise_d     = 1'b0;
    if (!en) begin
      level_hi_d = 1'b0;
    end else if (adc_valid) begin
      if (sample_ext >= THR_HI && !level_hi_q) begin
        level_hi_d = 1'b1;
        rise_d     = 1'b1;
      end else if (sample_ext <= THR_LO) begin
        level_hi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_hi_q <= 1'b0;
      rise_q     <= 1'b0;
    end else begin
      level_hi_q <= level_hi_d;
      rise_q     <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sig_freq_meter.sv
// Counts system clocks across N_PER signal periods; pulses meas_valid with the span or a timeout.
module sig_freq_meter
  import sig_meas_pkg::*;
#(
  parameter int unsigned DW          = 12,
  parameter int unsigned MID         = 2048,
  parameter int unsigned HYST        = 64,
  parameter int unsigned N_PER       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_en,
  input  logic             start,
  input  logic             adc_valid,
  input  logic [DW-1:0]    adc_data,
  output logic             meas_busy,
  output logic             meas_valid,
  output logic             meas_timeout,
  output logic [CNT_W-1:0] period_sum
);

  if (N_PER < 1) begin : g_bad_n_per
    $error("sig_freq_meter: N_PER must be at least 1");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("sig_freq_meter: TIMEOUT_CYC must be at least 1");
  end

  localparam int unsigned      EW        = edge_cnt_width(N_PER);
  localparam logic [EW-1:0]    LAST_EDGE = EW'(N_PER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  meas_state_e      state_q, state_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] period_sum_q, period_sum_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
  logic             rise;
  logic             tmo_hit;

  xing_detect #(
    .DW   (DW),
    .MID  (MID),
    .HYST (HYST)
  ) u_xing_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (meas_en),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .rise      (rise)
  );

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d      = state_q;
    timeout_d    = timeout_q;
    period_sum_d = period_sum_q;
    tmo_cnt_d    = tmo_cnt_q;
    clk_cnt_d    = clk_cnt_q;
    edge_cnt_d   = edge_cnt_q;

    if (!meas_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StArm;
            tmo_cnt_d  = '0;
            edge_cnt_d = '0;
          end
        end
        StArm: begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          // A first edge on the last allowed cycle cannot complete, so timeout wins here.
          if (tmo_hit) begin
            state_d      = StDone;
            period_sum_d = '0;
            timeout_d    = 1'b1;
          end else if (rise) begin
            state_d    = StMeas;
            clk_cnt_d  = '0;
            edge_cnt_d = '0;
          end
        end
        StMeas: begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
          if (rise) begin
            edge_cnt_d = edge_cnt_q + EW'(1);
          end
          // Terminal edge takes priority over a coincident timeout.
          if (rise && edge_cnt_q == LAST_EDGE) begin
            state_d      = StDone;
            period_sum_d = clk_cnt_q + CNT_W'(1);
            timeout_d    = 1'b0;
          end else if (tmo_hit) begin
            state_d      = StDone;
            period_sum_d = '0;
            timeout_d    = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
      endcase
    end

    busy_d  = (state_d == StArm) || (state_d == StMeas);
    valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      period_sum_q <= '0;
      tmo_cnt_q    <= '0;
      clk_cnt_q    <= '0;
      edge_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      period_sum_q <= period_sum_d;
      tmo_cnt_q    <= tmo_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
    end
  end

  assign meas_busy    = busy_q;
  assign meas_valid   = valid_q;
  assign meas_timeout = timeout_q;
  assign period_sum   = period_sum_q;

endmodule

// File: tb/tb_sig_freq_meter.sv
// Scoreboard bench: three meter instances share one waveform; expected results queued at start.
module tb_sig_freq_meter;

  typedef struct {
    int     dut;
    longint sum;
    longint tol;
    bit     tmo;
    longint cyc;  // expected valid cycle, -1 when not pinned
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  meas_en;
  logic [2:0]  start;
  logic        adc_valid;
  logic [11:0] adc_data;
  logic [2:0]  busy_w;
  logic [2:0]  valid_w;
  logic [2:0]  tmo_w;
  logic [31:0] sum_w [3];

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  int     mode     = 0;  // 0 sawtooth, 1 sine (valid every 2nd clk), 2 DC with noise
  int     per      = 100;
  int     ph       = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // a: N_PER=16; b: N_PER=4 sine; c: N_PER=4 with a short timeout
  sig_freq_meter #(.N_PER(16), .TIMEOUT_CYC(4000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en[0]), .start(start[0]),
    .adc_valid(adc_valid), .adc_data(adc_data), .meas_busy(busy_w[0]),
    .meas_valid(valid_w[0]), .meas_timeout(tmo_w[0]), .period_sum(sum_w[0])
  );
  sig_freq_meter #(.N_PER(4), .TIMEOUT_CYC(2000)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en[1]), .start(start[1]),
    .adc_valid(adc_valid), .adc_data(adc_data), .meas_busy(busy_w[1]),
    .meas_valid(valid_w[1]), .meas_timeout(tmo_w[1]), .period_sum(sum_w[1])
  );
  sig_freq_meter #(.N_PER(4), .TIMEOUT_CYC(1000)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .meas_en(meas_en[2]), .start(start[2]),
    .adc_valid(adc_valid), .adc_data(adc_data), .meas_busy(busy_w[2]),
    .meas_valid(valid_w[2]), .meas_timeout(tmo_w[2]), .period_sum(sum_w[2])
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive n cycles of the current waveform; returns #1 after a rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: begin
          adc_valid = 1'b1;
          adc_data  = 12'(((ph % per) * 4096) / per);
        end
        1: begin
          adc_valid = (ph % 2 == 0);
          if (ph % 2 == 0)
            adc_data = 12'(2048 + $rtoi(1800.0 * $sin(6.283185307179586 * real'(ph) / 250.0)));
        end
        default: begin
          adc_valid = 1'b1;
          adc_data  = 12'(2008 + $urandom_range(80, 0));
        end
      endcase
      @(posedge clk);
      #1;
      ph++;
    end
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    run(1);
    start[d] = 1'b0;
  endtask

  task automatic expect_meas(input int d, input longint sum, input longint tol, input bit tmo,
                             input longint vcyc);
    exp_t e;
    e.dut = d; e.sum = sum; e.tol = tol; e.tmo = tmo; e.cyc = vcyc;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (valid_w[d]) begin
        check_eq($sformatf("busy_at_valid_dut%0d", d), busy_w[d], 0);
        if (sb_q.size() == 0) begin
          check_eq($sformatf("spurious_valid_dut%0d", d), valid_w[d], 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_eq("valid_dut_id", d, e.dut);
          if (e.tol != 0)
            check_eq($sformatf("period_sum_in_window_%0d", e.sum),
                     longint'(sum_w[d] >= e.sum - e.tol && sum_w[d] <= e.sum + e.tol), 1);
          else
            check_eq("period_sum", sum_w[d], e.sum);
          check_eq("meas_timeout", tmo_w[d], e.tmo);
          if (e.cyc >= 0)
            check_eq("valid_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    meas_en   = '0;
    start     = '0;
    adc_valid = 1'b0;
    adc_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_eq($sformatf("rst_busy%0d", d), busy_w[d], 0);
      check_eq($sformatf("rst_valid%0d", d), valid_w[d], 0);
      check_eq($sformatf("rst_tmo%0d", d), tmo_w[d], 0);
      check_eq($sformatf("rst_sum%0d", d), sum_w[d], 0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    meas_en = 3'b111;

    // Sawtooth, P=100, N_PER=16
    mode = 0; per = 100; ph = 0;
    run(50);
    expect_meas(0, 1600, 0, 0, -1);
    pulse_start(0);
    run(30);
    check_eq("saw_busy_during", busy_w[0], 1);
    run(2000);
    check_eq("saw_all_results_seen", sb_q.size(), 0);
    check_eq("saw_busy_after", busy_w[0], 0);
    check_eq("saw_sum_held", sum_w[0], 1600);

    // Sine, P=250, sampled every 2nd clk, N_PER=4
    mode = 1; ph = 0;
    run(20);
    expect_meas(1, 1000, 2, 0, -1);
    pulse_start(1);
    run(1500);
    check_eq("sine_all_results_seen", sb_q.size(), 0);

    // DC inside the hysteresis band: timeout after exactly TIMEOUT_CYC clocks
    mode = 2;
    run(20);
    expect_meas(2, 0, 0, 1, cyc + 1 + 1000);
    pulse_start(2);
    run(1100);
    check_eq("dc_all_results_seen", sb_q.size(), 0);
    check_eq("dc_tmo_held", tmo_w[2], 1);

    // Terminal rise exactly at the last timeout cycle: first rise at tmo 199, last at 999
    mode = 0; per = 200; ph = 85;
    run(20);
    expect_meas(2, 800, 0, 0, cyc + 1 + 1000);
    pulse_start(2);
    run(1100);
    check_eq("edge_all_results_seen", sb_q.size(), 0);

    // Second start during MEAS is ignored
    per = 100; ph = 0;
    run(50);
    expect_meas(0, 1600, 0, 0, -1);
    pulse_start(0);
    run(400);
    check_eq("restart_busy", busy_w[0], 1);
    pulse_start(0);
    run(2500);
    check_eq("restart_all_results_seen", sb_q.size(), 0);

    // meas_en dropped mid-MEAS: no valid, results retained
    per = 125; ph = 0;
    run(50);
    pulse_start(0);
    run(600);
    check_eq("abort_busy_before", busy_w[0], 1);
    meas_en[0] = 1'b0;
    run(1);
    check_eq("abort_busy_after", busy_w[0], 0);
    check_eq("abort_sum_kept", sum_w[0], 1600);
    run(5);
    meas_en[0] = 1'b1;
    run(2500);
    check_eq("abort_sum_still_kept", sum_w[0], 1600);
    check_eq("abort_busy_idle", busy_w[0], 0);

    // Async reset mid-MEAS, then a fresh measurement
    per = 100; ph = 0;
    run(50);
    pulse_start(0);
    run(500);
    check_eq("rst_mid_busy_before", busy_w[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", busy_w[0], 0);
    check_eq("rst_mid_valid", valid_w[0], 0);
    check_eq("rst_mid_sum_a", sum_w[0], 0);
    check_eq("rst_mid_sum_c", sum_w[2], 0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_meas(0, 1600, 0, 0, -1);
    pulse_start(0);
    run(2000);
    check_eq("post_rst_all_results_seen", sb_q.size(), 0);
    check_eq("post_rst_sum", sum_w[0], 1600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
